// File: rtl/prog_loader.sv
// prog_loader: streams a burst of words into consecutive locations of the
// sequencer's synchronous memory, then fires a one-cycle run pulse.
//
// Optional feature macro: LOADER_CHECKSUM_EN (running sum of loaded words).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      begin a load (only sampled in IDLE)
//   base_addr  first write address, latched on a legal start
//   len        word count 1..WORDS, latched on a legal start
//   abort      cancel the load (honoured in LOAD and FLUSH)
//   in_valid / in_data / in_ready   input word stream
//   mem_load / mem_addr / mem_d     registered memory write port
//   run        one-cycle pulse to the sequencer after the last write
//   busy       state is not IDLE
//   done       one-cycle pulse when a load completes
//   err        sticky: last start had an illegal len
//   checksum   sum of loaded words (0 unless LOADER_CHECKSUM_EN)
//   dbg_state  current FSM state
//
// Stream handshake: a word transfers on a rising edge where in_valid and
// in_ready are both high. in_ready depends on state only; in_valid may be
// raised or dropped freely. Once raised, in_data must be stable until the
// transfer edge. A word offered in a cycle that also carries abort is dropped.
module prog_loader #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 12,
  parameter int WORDS  = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   len,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              mem_load,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_d,
  output logic              run,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DWIDTH-1:0] checksum,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_GO    = 2'd3
  } state_t;

  localparam logic [AWIDTH:0] LP_WORDS = (AWIDTH+1)'(WORDS);
  localparam logic [AWIDTH:0] LP_ONE   = (AWIDTH+1)'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [AWIDTH-1:0]   r_ptr;
  logic [AWIDTH:0]     r_rem;
  logic                r_mem_load;
  logic [AWIDTH-1:0]   r_mem_addr;
  logic [DWIDTH-1:0]   r_mem_d;
  logic                r_err;
  logic                w_len_ok;
  logic                w_start_ok;
  logic                w_start_bad;
  logic                w_beat;

  always_comb begin
    w_state_nxt = r_state;
    w_len_ok    = (len != '0) && (len <= LP_WORDS);
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    w_beat      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (w_len_ok) begin
            w_start_ok  = 1'b1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_start_bad = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        // abort wins over a coincident beat so nothing new is written
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (in_valid) begin
          w_beat = 1'b1;
          if (r_rem == LP_ONE) w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // the final write is already on the port; abort only suppresses run
        w_state_nxt = abort ? ST_IDLE : ST_GO;
      end
      ST_GO: begin
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_rem      <= '0;
      r_mem_load <= 1'b0;
      r_mem_addr <= '0;
      r_mem_d    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mem_load <= w_beat;
      if (w_start_ok) begin
        r_ptr <= base_addr;
        r_rem <= len;
        r_err <= 1'b0;
      end else if (w_start_bad) begin
        r_err <= 1'b1;
      end
      if (w_beat) begin
        r_mem_addr <= r_ptr;
        r_mem_d    <= in_data;
        r_ptr      <= r_ptr + AWIDTH'(1);  // wraps modulo memory depth
        r_rem      <= r_rem - LP_ONE;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [DWIDTH-1:0] r_checksum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_checksum <= '0;
    end else if (w_start_ok) begin
      r_checksum <= '0;
    end else if (w_beat) begin
      r_checksum <= r_checksum + in_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

  assign in_ready  = (r_state == ST_LOAD);
  assign run       = (r_state == ST_GO);
  assign done      = (r_state == ST_GO);
  assign busy      = (r_state != ST_IDLE);
  assign err       = r_err;
  assign mem_load  = r_mem_load;
  assign mem_addr  = r_mem_addr;
  assign mem_d     = r_mem_d;
  assign dbg_state = r_state;

endmodule
